rib_dma_master: RTL
===================

Name: rib_dma_master

Overview:
- Word-copy DMA engine that acts as a bus initiator on a spare RIB master port (m2 or m3).
- Once started, it copies len_i 32-bit words from a source address to a destination address.
- Each word is one RIB read followed by one RIB write, both stalled by the bus grant.
- Used to move images from data_mem into inst_mem and to do block copies without the core.

Parameters:
- AW, 32, address width; matches CPU_WIDTH.
- DW, 32, data width; matches CPU_WIDTH.
- LEN_W, 16, width of the word-count field.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  one-cycle start pulse; sampled only in IDLE.
- src_addr_i  input  AW  source byte address; captured on accepted start.
- dst_addr_i  input  AW  destination byte address; captured on accepted start.
- len_i  input  LEN_W  number of words to copy; captured on accepted start.
- busy_o  output  1  high from accepted start until the DONE cycle, inclusive.
- done_o  output  1  one-cycle pulse at end of transfer.
- m_req_o  output  1  RIB request.
- m_we_o  output  1  RIB write enable; 0 = read.
- m_addr_o  output  AW  RIB address.
- m_data_o  output  DW  RIB write data.
- m_data_i  input  DW  RIB read data; valid combinationally in a granted read cycle.
- m_gnt_i  input  1  high when this master owns the bus this cycle (request accepted).
- int_o  output  1  interrupt; only with DMA_IRQ_EN.
- int_clr_i  input  1  interrupt clear; only with DMA_IRQ_EN.

Behaviour:
- Reset (async, immediate): state IDLE; the following outputs go to 0:
  - busy_o, done_o, m_req_o, m_we_o;
  - m_addr_o, m_data_o;
  - int_o.
  - Internal src, dst, count and buffer registers also clear.
  - A reset mid-transfer drops m_req_o in the same cycle; the partial copy is not resumed.
- States:
  - IDLE:
    - start_i=1 captures src, dst, len and sets cnt=len.
    - If len!=0, go to RD; if len==0, go to DONE with no bus traffic.
  - RD: m_req_o=1, m_we_o=0, m_addr_o=src, m_data_o=0.
    - If m_gnt_i=1, latch m_data_i into buf and go to WR.
    - Otherwise hold all outputs and stay in RD.
  - WR: m_req_o=1, m_we_o=1, m_addr_o=dst, m_data_o=buf.
    - If m_gnt_i=1: src+=4, dst+=4, cnt-=1.
    - Then go to DONE if cnt was 1, else to RD.
    - Otherwise hold and stay in WR.
  - DONE: done_o=1, busy_o=1, m_req_o=0 for exactly one cycle, then IDLE.
- m_req_o is registered. Its outputs are driven from state registers, so there are no combinational paths from m_gnt_i to m_req_o/m_addr_o.
- Throughput: 2 cycles per word with continuous grant. A transfer of N>0 words takes 2N+1 cycles from the cycle after start to the DONE cycle inclusive.
- start_i while busy_o=1 is ignored; the captured parameters are not disturbed.
- Address arithmetic is modulo 2^AW (0xFFFFFFFC+4 wraps to 0x00000000).
- Low two address bits are passed through unmodified. Alignment is the software's responsibility.
- m_gnt_i low for any number of cycles stalls the current phase with stable outputs. No request is ever dropped or duplicated.
- Overlapping src/dst ranges are copied in ascending address order; no overlap correction.

Optional Feature:
- Macro: DMA_IRQ_EN.
- With DMA_IRQ_EN:
  - int_o sets to 1 in the cycle after DONE and stays high until int_clr_i=1.
  - int_clr_i clears int_o on the next edge.
  - Simultaneous set and clear: set wins.
- Without DMA_IRQ_EN:
  - int_o is tied to 0.
  - int_clr_i is ignored.
  - No interrupt register is synthesised.

Test Plan:
- Basic copy:
  - Stimulus: src=0x1000, dst=0x2000, len=3, m_gnt_i=1 constantly; memory model returns 0xA0,0xA1,0xA2.
  - Required: writes 0xA0@0x2000, 0xA1@0x2004, 0xA2@0x2008; done_o pulses 7 cycles after start.
- Zero length:
  - Stimulus: start with len=0.
  - Required: no m_req_o; done_o pulses on the cycle after start; busy_o high for that one cycle only.
- Grant stall:
  - Stimulus: len=1; hold m_gnt_i=0 for 5 cycles in RD and 3 cycles in WR.
  - Required: m_addr_o and m_we_o remain stable throughout; exactly one read and one write occur; done_o arrives 8 cycles late.
- Wrap-around and busy start:
  - Stimulus: src=0xFFFFFFFC, len=2; pulse start_i again mid-transfer with len=9.
  - Required: reads at 0xFFFFFFFC then 0x00000000; the second start is ignored; exactly 2 words are copied.
- Reset mid-transfer:
  - Stimulus: assert rst asynchronously during a WR phase.
  - Required: m_req_o=0 immediately; busy_o=0; a fresh start after release completes correctly.
- IRQ:
  - Requires DMA_IRQ_EN.
  - Stimulus: finish a transfer, wait 4 cycles, pulse int_clr_i.
  - Required: int_o is high from DONE+1 until the edge after int_clr_i. With the macro off, int_o stays 0.

Source files
------------

// File: rtl/rib_dma_master_if.sv
// Port bundle of the RIB DMA master: software control/status plus the RIB initiator signals.
// The master modport is the DMA side; the slave modport is the bus/controller side.
interface rib_dma_master_if #(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int LEN_W = 16
);
   logic             start_i;
   logic [AW-1:0]    src_addr_i;
   logic [AW-1:0]    dst_addr_i;
   logic [LEN_W-1:0] len_i;
   logic             busy_o;
   logic             done_o;
   logic             m_req_o;
   logic             m_we_o;
   logic [AW-1:0]    m_addr_o;
   logic [DW-1:0]    m_data_o;
   logic [DW-1:0]    m_data_i;
   logic             m_gnt_i;
   logic             int_o;
   logic             int_clr_i;

   modport master (
      input  start_i, src_addr_i, dst_addr_i, len_i, m_data_i, m_gnt_i, int_clr_i,
      output busy_o, done_o, m_req_o, m_we_o, m_addr_o, m_data_o, int_o
   );

   modport slave (
      output start_i, src_addr_i, dst_addr_i, len_i, m_data_i, m_gnt_i, int_clr_i,
      input  busy_o, done_o, m_req_o, m_we_o, m_addr_o, m_data_o, int_o
   );
endinterface

// File: rtl/rib_dma_master.sv
// Word-copy DMA on a spare RIB master port: one read then one write per word, stalled by m_gnt_i.
// Define DMA_IRQ_EN to add a sticky completion interrupt (int_o, cleared by int_clr_i).
module rib_dma_master #(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   rib_dma_master_if.master bus
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    src_q, src_d;
   logic [AW-1:0]    dst_q, dst_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    data_buf_q, data_buf_d;

   logic             req_q, req_d;
   logic             we_q, we_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [DW-1:0]    wdata_q, wdata_d;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      cnt_d      = cnt_q;
      data_buf_d = data_buf_q;

      case (state_q)
         IDLE: if (bus.start_i) begin
            src_d   = bus.src_addr_i;
            dst_d   = bus.dst_addr_i;
            cnt_d   = bus.len_i;
            state_d = (bus.len_i == '0) ? DONE : RD;
         end
         RD: if (bus.m_gnt_i) begin
            data_buf_d = bus.m_data_i;
            state_d    = WR;
         end
         WR: if (bus.m_gnt_i) begin
            src_d   = src_q + AW'(4);
            dst_d   = dst_q + AW'(4);
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = (cnt_q == LEN_W'(1)) ? DONE : RD;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Bus outputs are registered from the next-state decode, so m_gnt_i never reaches them combinationally.
      req_d   = (state_d == RD) || (state_d == WR);
      we_d    = (state_d == WR);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
      addr_d  = '0;
      wdata_d = '0;
      if (state_d == RD) begin
         addr_d = src_d;
      end else if (state_d == WR) begin
         addr_d  = dst_d;
         wdata_d = data_buf_d;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         cnt_q      <= '0;
         data_buf_q <= '0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         cnt_q      <= cnt_d;
         data_buf_q <= data_buf_d;
         req_q      <= req_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign bus.busy_o   = busy_q;
   assign bus.done_o   = done_q;
   assign bus.m_req_o  = req_q;
   assign bus.m_we_o   = we_q;
   assign bus.m_addr_o = addr_q;
   assign bus.m_data_o = wdata_q;

`ifdef DMA_IRQ_EN
   logic int_q;

   // Set has priority over clear so a completion is never lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_q <= 1'b0;
      end else if (state_q == DONE) begin
         int_q <= 1'b1;
      end else if (bus.int_clr_i) begin
         int_q <= 1'b0;
      end
   end

   assign bus.int_o = int_q;
`else
   logic unused_int_clr;

   assign unused_int_clr = bus.int_clr_i;
   assign bus.int_o      = 1'b0;
`endif

endmodule
